// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and the byte-sequencer state encoding.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_B    = 3'd1;
    localparam logic [2:0] ST_WAIT_OP   = 3'd2;
    localparam logic [2:0] ST_EXEC      = 3'd3;
    localparam logic [2:0] ST_SEND      = 3'd4;
    localparam logic [2:0] ST_WAIT_TX   = 3'd5;
    localparam logic [2:0] ST_SEND_C    = 3'd6;
    localparam logic [2:0] ST_WAIT_TX_C = 3'd7;

    // States in which an incoming RX byte is consumed rather than dropped
    function automatic logic rx_open(input logic [2:0] st);
        return (st == ST_IDLE) || (st == ST_WAIT_B) || (st == ST_WAIT_OP);
    endfunction

endpackage

// File: rtl/alu_ctrl_timer.sv
// Inter-byte watchdog: counts while enabled, flags expiry at TIMEOUT-1; TIMEOUT=0 disables it.
module alu_ctrl_timer #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [TW-1:0] cnt_r;

    // Cycle counter, restarted by every accepted byte and while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (TIMEOUT != 0)) begin
            cnt_r <= cnt_r + TW'(1);
        end
    end

    assign expire = (TIMEOUT != 0) && en && (cnt_r == TW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_uart_ctrl.sv
// Byte-stream sequencer: gathers A, B, opcode from RX, latches the ALU result and returns it on TX.
// Optional feature macro: ALU_CTRL_CARRY_TX_EN (appends a carry byte after the result byte).
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6,
    parameter int TIMEOUT  = 50000
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [SIZEDATA-1:0] RX_DATA,
    input  logic                RX_VALID,
    input  logic                TX_BUSY,
    output logic [SIZEDATA-1:0] TX_DATA,
    output logic                TX_START,
    output logic [SIZEDATA-1:0] DATOA,
    output logic [SIZEDATA-1:0] DATOB,
    output logic [SIZEOP-1:0]   OPCODE,
    input  logic [SIZEDATA-1:0] ALU_RESULT,
    input  logic                ALU_CARRY,
    output logic                BUSY,
    output logic                TIMEOUT_ERR,
    output logic                OVERRUN
);

    logic [2:0]          state_r;
    logic [2:0]          state_next_s;
    logic                accept_s;
    logic                tx_fire_s;
    logic [SIZEDATA-1:0] tx_byte_s;
    logic                expire_s;
    logic                timeout_s;
    logic                overrun_s;
    logic                guard_r;
    logic [SIZEDATA-1:0] res_r;
    logic [SIZEDATA-1:0] datoa_r;
    logic [SIZEDATA-1:0] datob_r;
    logic [SIZEOP-1:0]   opcode_r;
    logic [SIZEDATA-1:0] tx_data_r;
    logic                tx_start_r;
    logic                busy_r;
    logic                timeout_err_r;
    logic                overrun_r;
`ifdef ALU_CTRL_CARRY_TX_EN
    logic                cry_r;
`else
    logic                unused_s;
    assign unused_s = ALU_CARRY;
`endif

    alu_ctrl_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .clr    (accept_s || (state_r == ST_IDLE)),
        .en     ((state_r == ST_WAIT_B) || (state_r == ST_WAIT_OP)),
        .expire (expire_s)
    );

    // A byte arriving on the expiry cycle is accepted and suppresses the timeout
    assign timeout_s = expire_s && !RX_VALID;
    assign overrun_s = RX_VALID && !rx_open(state_r);

    // Next-state, byte acceptance and transmit launch decode
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        tx_fire_s    = 1'b0;
        tx_byte_s    = res_r;
        case (state_r)
            ST_IDLE: begin
                if (RX_VALID) begin
                    state_next_s = ST_WAIT_B;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_B: begin
                if (RX_VALID) begin
                    state_next_s = ST_WAIT_OP;
                    accept_s     = 1'b1;
                end else if (expire_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_B;
                end
            end
            ST_WAIT_OP: begin
                if (RX_VALID) begin
                    state_next_s = ST_EXEC;
                    accept_s     = 1'b1;
                end else if (expire_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_OP;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_SEND;
            end
            ST_SEND: begin
                if (!TX_BUSY) begin
                    state_next_s = ST_WAIT_TX;
                    tx_fire_s    = 1'b1;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_WAIT_TX: begin
                if (!guard_r && !TX_BUSY) begin
`ifdef ALU_CTRL_CARRY_TX_EN
                    state_next_s = ST_SEND_C;
`else
                    state_next_s = ST_IDLE;
`endif
                end else begin
                    state_next_s = ST_WAIT_TX;
                end
            end
`ifdef ALU_CTRL_CARRY_TX_EN
            ST_SEND_C: begin
                tx_byte_s = {{(SIZEDATA-1){1'b0}}, cry_r};
                if (!TX_BUSY) begin
                    state_next_s = ST_WAIT_TX_C;
                    tx_fire_s    = 1'b1;
                end else begin
                    state_next_s = ST_SEND_C;
                end
            end
            ST_WAIT_TX_C: begin
                if (!guard_r && !TX_BUSY) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_TX_C;
                end
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, operand, result and output registers; every output is driven from a flop
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r       <= ST_IDLE;
            guard_r       <= 1'b0;
            res_r         <= '0;
            datoa_r       <= '0;
            datob_r       <= '0;
            opcode_r      <= '0;
            tx_data_r     <= '0;
            tx_start_r    <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            overrun_r     <= 1'b0;
`ifdef ALU_CTRL_CARRY_TX_EN
            cry_r         <= 1'b0;
`endif
        end else begin
            state_r       <= state_next_s;
            busy_r        <= (state_next_s != ST_IDLE);
            guard_r       <= tx_fire_s;
            tx_start_r    <= tx_fire_s;
            timeout_err_r <= timeout_s;
            overrun_r     <= overrun_s;
            if (accept_s) begin
                case (state_r)
                    ST_IDLE:    datoa_r  <= RX_DATA;
                    ST_WAIT_B:  datob_r  <= RX_DATA;
                    ST_WAIT_OP: opcode_r <= RX_DATA[SIZEOP-1:0];
                    default:    datoa_r  <= datoa_r;
                endcase
            end
            if (state_r == ST_EXEC) begin
                res_r <= ALU_RESULT;
`ifdef ALU_CTRL_CARRY_TX_EN
                cry_r <= ALU_CARRY;
`endif
            end
            if (tx_fire_s) begin
                tx_data_r <= tx_byte_s;
            end
        end
    end

    assign TX_DATA     = tx_data_r;
    assign TX_START    = tx_start_r;
    assign DATOA       = datoa_r;
    assign DATOB       = datob_r;
    assign OPCODE      = opcode_r;
    assign BUSY        = busy_r;
    assign TIMEOUT_ERR = timeout_err_r;
    assign OVERRUN     = overrun_r;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl with a behavioural ALU and a simple TX handshake responder.
module tb_alu_uart_ctrl;
    import alu_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       TX_BUSY;
    logic [7:0] TX_DATA;
    logic       TX_START;
    logic [7:0] DATOA;
    logic [7:0] DATOB;
    logic [5:0] OPCODE;
    logic [7:0] ALU_RESULT;
    logic       ALU_CARRY;
    logic       BUSY;
    logic       TIMEOUT_ERR;
    logic       OVERRUN;

    int n_checks = 0;
    int n_errors = 0;
    int tx_count = 0;
    int to_count = 0;

    always #5 CLK = ~CLK;

    alu_uart_ctrl #(.SIZEDATA(8), .SIZEOP(6), .TIMEOUT(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .TX_BUSY(TX_BUSY), .TX_DATA(TX_DATA), .TX_START(TX_START),
        .DATOA(DATOA), .DATOB(DATOB), .OPCODE(OPCODE),
        .ALU_RESULT(ALU_RESULT), .ALU_CARRY(ALU_CARRY),
        .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR), .OVERRUN(OVERRUN)
    );

    // Behavioural combinational ALU sitting outside the controller
    always_comb begin
        logic [8:0] wide;
        wide       = 9'd0;
        ALU_RESULT = 8'h00;
        ALU_CARRY  = 1'b0;
        case (OPCODE)
            OP_ADD: begin wide = {1'b0, DATOA} + {1'b0, DATOB}; ALU_RESULT = wide[7:0]; ALU_CARRY = wide[8]; end
            OP_SUB: begin wide = {1'b0, DATOA} - {1'b0, DATOB}; ALU_RESULT = wide[7:0]; ALU_CARRY = wide[8]; end
            OP_AND: ALU_RESULT = DATOA & DATOB;
            OP_OR:  ALU_RESULT = DATOA | DATOB;
            OP_XOR: ALU_RESULT = DATOA ^ DATOB;
            OP_NOR: ALU_RESULT = ~(DATOA | DATOB);
            OP_SRA: ALU_RESULT = $signed(DATOB) >>> DATOA[2:0];
            OP_SRL: ALU_RESULT = DATOB >> DATOA[2:0];
            default: ALU_RESULT = 8'h00;
        endcase
    end

    // Pulse counters; sampled at the rising edge so they see the previous cycle's value
    always @(posedge CLK) begin
        if (TX_START) tx_count++;
        if (TIMEOUT_ERR) to_count++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller sits on a falling edge; byte is taken at the following rising edge
    task automatic send_byte(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    task automatic wait_tx_start(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (!TX_START && cycles < budget) begin
            @(negedge CLK);
            cycles++;
        end
        check_eq({tag, "_tx_start"}, TX_START, 1);
    endtask

    task automatic finish_tx();
        TX_BUSY = 1'b1;
        repeat (3) @(negedge CLK);
        TX_BUSY = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (BUSY && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check_eq({tag, "_idle"}, BUSY, 0);
    endtask

    // Follows a transaction from the cycle after the opcode byte to IDLE
    task automatic complete_txn(input string tag, input logic [7:0] exp_res, input logic exp_c,
                                input int hold, input int tx0);
        int lat;
        if (hold > 0) begin
            repeat (hold) @(negedge CLK);
            check_eq({tag, "_held"}, tx_count + int'(TX_START), tx0);
            TX_BUSY = 1'b0;
        end
        wait_tx_start(tag, 40, lat);
        if (hold == 0) check_eq({tag, "_latency"}, lat, 2);
        check_eq({tag, "_result"}, TX_DATA, exp_res);
        finish_tx();
`ifdef ALU_CTRL_CARRY_TX_EN
        wait_tx_start({tag, "_c"}, 40, lat);
        check_eq({tag, "_carry"}, TX_DATA, {7'b0, exp_c});
        finish_tx();
`else
        if (exp_c === 1'bx) check_eq({tag, "_carry_known"}, exp_c, 0);
`endif
        wait_idle(tag);
`ifdef ALU_CTRL_CARRY_TX_EN
        check_eq({tag, "_tx_count"}, tx_count, tx0 + 2);
`else
        check_eq({tag, "_tx_count"}, tx_count, tx0 + 1);
`endif
    endtask

    task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp_res, input logic exp_c,
                           input int hold);
        int tx0;
        @(negedge CLK);
        tx0 = tx_count;
        if (hold > 0) TX_BUSY = 1'b1;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        complete_txn(tag, exp_res, exp_c, hold, tx0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx0;
        int to0;
        int cnt;
        RESET_N  = 1'b0;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        TX_BUSY  = 1'b0;
        #2;
        check_eq("reset_outputs", {TX_DATA, TX_START, DATOA, DATOB, OPCODE, BUSY, TIMEOUT_ERR, OVERRUN}, 0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;

        run_txn("add", 8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 0);
        run_txn("sub", 8'h03, 8'h05, 8'h22, 8'hFE, 1'b1, 0);
        run_txn("add_busy", 8'hFF, 8'h01, 8'h20, 8'h00, 1'b1, 20);
        run_txn("and_hibits", 8'hF3, 8'h3C, 8'hE4, 8'h30, 1'b0, 0);
        check_eq("opcode_masked", OPCODE, 6'h24);
        run_txn("unknown_op", 8'h12, 8'h34, 8'h3F, 8'h00, 1'b0, 0);
        check_eq("operands_held", {DATOA, DATOB}, 16'h1234);

        // Timeout after operand A only
        @(negedge CLK);
        tx0 = tx_count;
        send_byte(8'h44);
        cnt = 0;
        while (!TIMEOUT_ERR && cnt < 40) begin
            @(negedge CLK);
            cnt++;
        end
        check_eq("timeout_cycle", cnt, 16);
        check_eq("timeout_idle", BUSY, 0);
        @(negedge CLK);
        check_eq("timeout_pulse_width", TIMEOUT_ERR, 0);
        check_eq("timeout_no_tx", tx_count, tx0);
        check_eq("timeout_partial_kept", DATOA, 8'h44);

        // Byte arriving on the expiry cycle wins over the timeout
        to0 = to_count;
        tx0 = tx_count;
        send_byte(8'h02);
        repeat (15) @(negedge CLK);
        send_byte(8'h03);
        check_eq("race_no_timeout", TIMEOUT_ERR, 0);
        check_eq("race_still_busy", BUSY, 1);
        send_byte(8'h20);
        complete_txn("race", 8'h05, 1'b0, 0, tx0);
        check_eq("race_timeout_count", to_count, to0);

        // Overrun during WAIT_TX
        @(negedge CLK);
        tx0 = tx_count;
        send_byte(8'h10);
        send_byte(8'h22);
        send_byte(8'h20);
        wait_tx_start("ovr", 40, cnt);
        check_eq("ovr_result", TX_DATA, 8'h32);
        TX_BUSY = 1'b1;
        send_byte(8'h77);
        check_eq("ovr_pulse", OVERRUN, 1);
        check_eq("ovr_byte_dropped", DATOA, 8'h10);
        @(negedge CLK);
        check_eq("ovr_pulse_width", OVERRUN, 0);
        TX_BUSY = 1'b0;
`ifdef ALU_CTRL_CARRY_TX_EN
        wait_tx_start("ovr_c", 40, cnt);
        check_eq("ovr_carry", TX_DATA, 8'h00);
        finish_tx();
`endif
        wait_idle("ovr");
        run_txn("after_ovr", 8'h21, 8'h01, 8'h22, 8'h20, 1'b0, 0);

        // Reset while waiting for the opcode
        @(negedge CLK);
        tx0 = tx_count;
        send_byte(8'hAA);
        send_byte(8'h55);
        RESET_N = 1'b0;
        #1;
        check_eq("rst_mid_outputs", {TX_DATA, TX_START, DATOA, DATOB, OPCODE, BUSY, TIMEOUT_ERR, OVERRUN}, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (5) @(negedge CLK);
        check_eq("rst_mid_no_tx", tx_count, tx0);
        check_eq("rst_mid_idle", BUSY, 0);
        run_txn("after_rst", 8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
